axi_rd_arbiter: RTL and testbench



---
 rtl/axi_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin arbiter for the AXI4-Lite AR/R channels: one outstanding
// transaction, registered AR address, per-phase timeout answered with SLVERR.
module axi_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, AR, R, ERR} state_t;

  state_t            state, state_d;
  logic              grant, grant_d;
  logic              last_grant, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic              sel;
  logic              rready_g;
  logic              stall;
  logic              rvalid_g;
  logic [DATA_W-1:0] rdata_g;
  logic [1:0]        rresp_g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      addr_q     <= addr_d;
      cnt        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    addr_d       = addr_q;
    cnt_d        = cnt;
    stall        = 1'b0;
    s_araddr     = '0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    rvalid_g     = 1'b0;
    rdata_g      = '0;
    rresp_g      = '0;

    // On a tie the master that was not served last wins; otherwise the lone requester.
    sel      = (m0_arvalid & m1_arvalid) ? ~last_grant : m1_arvalid;
    rready_g = grant ? m1_rready : m0_rready;

    case (state)
      IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          m0_arready = ~sel;
          m1_arready = sel;
          addr_d     = sel ? m1_araddr : m0_araddr;
          grant_d    = sel;
          cnt_d      = '0;
          state_d    = AR;
        end
      end
      AR: begin
        s_arvalid = 1'b1;
        s_araddr  = addr_q;
        if (s_arready) begin
          cnt_d   = '0;
          state_d = R;
        end else begin
          stall = 1'b1;
        end
      end
      R: begin
        s_rready = rready_g;
        rvalid_g = s_rvalid;
        rdata_g  = s_rdata;
        rresp_g  = s_rresp;
        if (s_rvalid & rready_g) begin
          last_grant_d = grant;
          state_d      = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      ERR: begin
        rvalid_g = 1'b1;
        rresp_g  = 2'b10;
        if (rready_g) begin
          last_grant_d = grant;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stall && TIMEOUT != 0) begin
      if (cnt == CNT_LAST) state_d = ERR;
      else                 cnt_d   = cnt + 1'b1;
    end

    m0_rvalid = rvalid_g & ~grant;
    m0_rdata  = grant ? '0 : rdata_g;
    m0_rresp  = grant ? '0 : rresp_g;
    m1_rvalid = rvalid_g & grant;
    m1_rdata  = grant ? rdata_g : '0;
    m1_rresp  = grant ? rresp_g : '0;

    // Combinational arready would otherwise follow arvalid while reset is held.
    if (rst) begin
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      m0_rdata   = '0;
      m1_rdata   = '0;
      m0_rresp   = '0;
      m1_rresp   = '0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_rready   = 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised scoreboard bench for axi_rd_arbiter: master/slave behavioural agents,
// expected responses queued at issue and checked by an independent monitor.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]    m0_rresp, m1_rresp, s_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  rsp_t        exp_r0[$], exp_r1[$];
  logic [31:0] exp_a0[$], exp_a1[$];
  logic [31:0] s_pend[$];
  logic [31:0] sar_log[$];
  bit          grant_log[$];

  // stimulus knobs
  int          left[2];
  int          rr_mode[2];
  int          p_issue, p_sar, rdly_min, rdly_max, err_kind;
  bit          r_never, fix_addr, use_ovr;
  logic [31:0] ovr_data;

  // agent and model state
  bit          eng_en, mon_en;
  bit          out[2];
  int          issue_cyc[2], last_lat[2], rv_wait[2];
  int          rdly, sar_stall;
  bit          busy, owner, last_served;
  bit          hs_ar0, hs_ar1, hs_sar, hs_sr, hs_r0, hs_r1;
  logic [31:0] sar_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[4] ? 2'b10 : 2'b00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i);
    logic [31:0] a;
    rsp_t        e;
    a = (i == 1) ? 32'h8000_0000 : 32'h3000_0000;
    if (!fix_addr) a = a | ($urandom & 32'h0000_FFFC);
    if (err_kind != 0)  e = '{data: 32'h0, resp: 2'b10};
    else if (use_ovr)   e = '{data: ovr_data, resp: 2'b00};
    else                e = '{data: data_of(a), resp: resp_of(a)};
    if (i == 0) begin
      exp_r0.push_back(e);
      if (err_kind != 1) exp_a0.push_back(a);
      m0_araddr = a; m0_arvalid = 1'b1;
    end else begin
      exp_r1.push_back(e);
      if (err_kind != 1) exp_a1.push_back(a);
      m1_araddr = a; m1_arvalid = 1'b1;
    end
    out[i]       = 1'b1;
    left[i]      = left[i] - 1;
    issue_cyc[i] = cyc + 1;
  endtask

  function automatic logic rr_val(input int i);
    if (rr_mode[i] == 1) return 1'b1;
    if (rr_mode[i] == 2) return 1'b0;
    return (rv_wait[i] >= 2) ? 1'b1 : 1'($urandom_range(1));
  endfunction

  // Master and slave agents act just after each rising edge on the handshakes
  // the monitor saw at the preceding falling edge.
  always begin
    @(posedge clk);
    #1;
    if (eng_en) begin
      if (hs_ar0) m0_arvalid = 1'b0;
      if (hs_ar1) m1_arvalid = 1'b0;
      if (hs_r0) out[0] = 1'b0;
      if (hs_r1) out[1] = 1'b0;
      for (int i = 0; i < 2; i++)
        if (!out[i] && left[i] > 0 && int'($urandom_range(99)) < p_issue) issue(i);
      m0_rready = rr_val(0);
      m1_rready = rr_val(1);

      if (hs_sr) begin
        s_rvalid = 1'b0;
        if (s_pend.size() > 0) void'(s_pend.pop_front());
      end
      if (hs_sar) begin
        s_pend.push_back(sar_addr);
        rdly = int'($urandom_range(rdly_max, rdly_min));
      end
      if (!s_rvalid) begin
        s_rdata = $urandom;
        s_rresp = 2'($urandom_range(3));
        if (s_pend.size() > 0 && !r_never) begin
          if (rdly > 0) rdly--;
          else begin
            s_rvalid = 1'b1;
            s_rdata  = use_ovr ? ovr_data : data_of(s_pend[0]);
            s_rresp  = use_ovr ? 2'b00 : resp_of(s_pend[0]);
          end
        end
      end
      s_arready = (p_sar > 0) && (int'($urandom_range(99)) < p_sar || sar_stall >= 4);
    end
  end

  // Monitor: reference model of grant/ownership plus response scoreboard.
  always @(negedge clk) begin
    bit          b, w, own_rr;
    rsp_t        e;
    logic [31:0] a;
    cyc++;
    hs_ar0   = m0_arvalid && m0_arready;
    hs_ar1   = m1_arvalid && m1_arready;
    hs_sar   = s_arvalid && s_arready;
    hs_sr    = s_rvalid && s_rready;
    hs_r0    = m0_rvalid && m0_rready;
    hs_r1    = m1_rvalid && m1_rready;
    sar_addr = s_araddr;
    sar_stall  = (s_arvalid && !s_arready) ? sar_stall + 1 : 0;
    rv_wait[0] = (m0_rvalid && !m0_rready) ? rv_wait[0] + 1 : 0;
    rv_wait[1] = (m1_rvalid && !m1_rready) ? rv_wait[1] + 1 : 0;
    if (mon_en) begin
      b = busy;
      if (!b && (m0_arvalid || m1_arvalid)) begin
        w = (m0_arvalid && m1_arvalid) ? !last_served : m1_arvalid;
        check("grant", {m0_arready, m1_arready}, w ? 2'b01 : 2'b10);
        busy  = 1'b1;
        owner = w;
        grant_log.push_back(w);
      end else begin
        check("arready_zero", {m0_arready, m1_arready}, 2'b00);
      end
      if (!b) begin
        check("idle_ctrl", {s_arvalid, s_rready, m0_rvalid, m1_rvalid}, 4'b0000);
        check("idle_rdata", {m0_rdata, m1_rdata}, 64'd0);
      end else begin
        if (owner) check("m0_quiet", {m0_rvalid, m0_rresp, m0_rdata}, 64'd0);
        else       check("m1_quiet", {m1_rvalid, m1_rresp, m1_rdata}, 64'd0);
        own_rr = owner ? m1_rready : m0_rready;
        if (s_rready) check("s_rready_src", own_rr, 1'b1);
      end
      if (hs_sar) begin
        a = s_araddr;
        sar_log.push_back(a);
        if (a[31]) begin
          check("a1_pending", exp_a1.size() > 0, 1'b1);
          if (exp_a1.size() > 0) check("s_araddr_m1", a, exp_a1.pop_front());
        end else begin
          check("a0_pending", exp_a0.size() > 0, 1'b1);
          if (exp_a0.size() > 0) check("s_araddr_m0", a, exp_a0.pop_front());
        end
      end
      if (b && hs_r0) begin
        check("r0_pending", exp_r0.size() > 0, 1'b1);
        if (exp_r0.size() > 0) begin
          e = exp_r0.pop_front();
          check("m0_rdata", m0_rdata, e.data);
          check("m0_rresp", m0_rresp, e.resp);
        end
        busy = 1'b0; last_served = 1'b0;
        last_lat[0] = cyc - issue_cyc[0] + 1;
      end
      if (b && hs_r1) begin
        check("r1_pending", exp_r1.size() > 0, 1'b1);
        if (exp_r1.size() > 0) begin
          e = exp_r1.pop_front();
          check("m1_rdata", m1_rdata, e.data);
          check("m1_rresp", m1_rresp, e.resp);
        end
        busy = 1'b0; last_served = 1'b1;
        last_lat[1] = cyc - issue_cyc[1] + 1;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rresp, m1_rresp,
                            s_arvalid, s_rready}, 64'd0);
    check({name, "_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
    check({name, "_saddr"}, s_araddr, 64'd0);
  endtask

  task automatic do_reset();
    eng_en = 0; mon_en = 0; rst = 1'b1;
    m0_arvalid = 0; m1_arvalid = 0; m0_araddr = '0; m1_araddr = '0;
    m0_rready = 0; m1_rready = 0; s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    exp_r0.delete(); exp_r1.delete(); exp_a0.delete(); exp_a1.delete();
    s_pend.delete(); sar_log.delete(); grant_log.delete();
    busy = 0; owner = 0; last_served = 1; rdly = 0;
    for (int i = 0; i < 2; i++) begin out[i] = 0; left[i] = 0; end
    repeat (2) @(negedge clk);
    rst = 1'b0; eng_en = 1; mon_en = 1;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while ((left[0] > 0 || left[1] > 0 || out[0] || out[1]) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, n < limit, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic knobs(input int iss, input int sar, input int dmin, input int dmax,
                       input int rr0, input int rr1);
    p_issue = iss; p_sar = sar; rdly_min = dmin; rdly_max = dmax;
    rr_mode[0] = rr0; rr_mode[1] = rr1;
  endtask

  initial begin
    int n, k, g;
    err_kind = 0; r_never = 0; fix_addr = 0; use_ovr = 0; ovr_data = '0;
    knobs(100, 100, 0, 0, 1, 1);
    eng_en = 0; mon_en = 0;
    rst = 1'b1;
    m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h3000_0000; m1_araddr = 32'h8000_0000;
    m0_rready = 1; m1_rready = 1; s_arready = 1; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
    s_rresp = 2'b10;
    #3;
    check_reset_outputs("reset_hold");
    do_reset();

    // first tie after reset goes to m0, then m1
    fix_addr = 1;
    left[0] = 1; left[1] = 1;
    wait_done("tie", 100);
    check("tie_count", grant_log.size(), 2);
    for (int i = 0; i < 2; i++) begin
      g = (i < grant_log.size()) ? int'(grant_log[i]) : 9;
      check("tie_grant", g, i);
    end
    check("tie_saddr0", (sar_log.size() > 0) ? sar_log[0] : 32'hFFFF_FFFF, 32'h3000_0000);
    check("tie_saddr1", (sar_log.size() > 1) ? sar_log[1] : 32'hFFFF_FFFF, 32'h8000_0000);

    // sustained contention alternates m0,m1,...
    fix_addr = 0; grant_log.delete();
    knobs(100, 70, 0, 2, 0, 0);
    left[0] = 3; left[1] = 3;
    wait_done("contention", 300);
    for (int i = 0; i < 6; i++) begin
      g = (i < grant_log.size()) ? int'(grant_log[i]) : 9;
      check("contention_grant", g, i % 2);
    end

    // m0 alone, slave ready at once and data one cycle later
    fix_addr = 1; use_ovr = 1; ovr_data = 32'h0000_0413;
    knobs(100, 100, 1, 1, 1, 1);
    left[0] = 1;
    wait_done("m0_only", 50);
    check("m0_latency", last_lat[0], 4);
    use_ovr = 0;

    // m1 backpressure: rready low for 3 cycles while slave data is valid
    knobs(100, 100, 0, 0, 1, 2);
    left[1] = 1;
    k = 0;
    while (!m1_rvalid && k < 50) begin @(negedge clk); k++; end
    check("bp_reach", k < 50, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_s_rready", s_rready, 1'b0);
      check("bp_m1_rvalid", m1_rvalid, 1'b1);
      check("bp_m1_rdata", m1_rdata, data_of(32'h8000_0000));
      if (i < 2) @(negedge clk);
    end
    rr_mode[1] = 1;
    wait_done("backpressure", 20);
    fix_addr = 0;

    // random soak
    knobs(40, 60, 0, 2, 0, 0);
    left[0] = 25; left[1] = 25;
    wait_done("soak", 3000);

    // AR timeout: slave never accepts the address
    knobs(100, 0, 0, 0, 2, 1);
    err_kind = 1;
    left[0] = 1;
    n = 0; k = 0;
    while (!m0_rvalid && k < 100) begin
      @(negedge clk);
      k++;
      if (s_arvalid) n++;
    end
    check("ar_timeout_cycles", n, TO);
    check("ar_timeout_rresp", m0_rresp, 2'b10);
    check("ar_timeout_rdata", m0_rdata, 32'h0);
    check("ar_timeout_s_arvalid", s_arvalid, 1'b0);
    rr_mode[0] = 1;
    wait_done("ar_timeout", 20);

    // R timeout: slave accepts the address but never returns data
    knobs(100, 100, 0, 0, 1, 1);
    err_kind = 2; r_never = 1;
    left[1] = 1;
    wait_done("r_timeout", 50);
    s_pend.delete(); r_never = 0; err_kind = 0;

    // reset in the middle of R, with a second request pending
    knobs(100, 100, 30, 30, 1, 1);
    left[0] = 1;
    k = 0;
    while (!(s_arvalid && s_arready) && k < 50) begin @(negedge clk); k++; end
    check("midR_reach", k < 50, 1'b1);
    left[1] = 1;
    @(negedge clk);
    eng_en = 0; mon_en = 0;
    s_rvalid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_midR");
    do_reset();
    fix_addr = 1;
    knobs(100, 100, 0, 2, 1, 1);
    left[0] = 1; left[1] = 1;
    wait_done("post_reset_tie", 100);
    g = (grant_log.size() > 0) ? int'(grant_log[0]) : 9;
    check("post_reset_first_grant", g, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end
endmodule
